// File: rtl/seq_div_if.sv
// Request/response bundle for the multi-cycle divider.
// The requester (control unit or bench) drives start and the operands.
// The divider drives the status flags and the results.
interface seq_div_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;
  logic             overflow;

  modport master (
    output start,
    output signed_op,
    output a,
    output b,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_zero,
    input  overflow
  );

  modport slave (
    input  start,
    input  signed_op,
    input  a,
    input  b,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_zero,
    output overflow
  );
endinterface

// File: rtl/seq_div.sv
// Restoring radix-2 integer divider with a start/busy/done handshake.
// Each request is signed or unsigned. Quotient and remainder come back
// WIDTH cycles after acceptance. A zero divisor finishes in a single cycle.
// The core always divides magnitudes. The signs are applied on the last
// iteration, so the quotient truncates toward zero and the remainder
// follows the sign of the dividend.
module seq_div #(
  parameter int WIDTH = 8
) (
  input logic     clk,
  input logic     reset,
  seq_div_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Control state
  logic [0:0]    state_reg;
  logic [CW-1:0] cnt_reg;

  // Iteration datapath.
  // The partial remainder is always below the divisor, so it is stored in
  // WIDTH bits. The extra sign bit exists only in the WIDTH+1-bit trial
  // subtraction. Quotient bits shift into the low end of the dividend
  // register as the dividend bits shift out of the top.
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             ovf_pend_reg;

  // Registered, externally visible results
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             div_zero_reg;
  logic             overflow_reg;
  logic             done_reg;

  // Combinational helpers
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_is_zero;
  logic             ovf_case;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] dvd_step;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Operand conditioning at acceptance.
  // In signed mode the operands are reduced to magnitudes. The magnitude of
  // the most-negative value is 2^(WIDTH-1), which still fits as unsigned.
  always_comb begin
    a_mag     = bus.a;
    b_mag     = bus.b;
    if (bus.signed_op && bus.a[WIDTH-1]) begin
      a_mag = -bus.a;
    end
    if (bus.signed_op && bus.b[WIDTH-1]) begin
      b_mag = -bus.b;
    end
    b_is_zero = (bus.b == '0);
    ovf_case  = bus.signed_op && (bus.a == MIN_NEG) && (&bus.b);
  end

  // One restoring step, followed by the sign fix-up for the final iteration.
  always_comb begin
    shifted  = {rem_reg, dvd_reg[WIDTH-1]};
    trial    = shifted - {1'b0, dvs_reg};
    q_bit    = ~trial[WIDTH];
    rem_step = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_step = {dvd_reg[WIDTH-2:0], q_bit};
    q_fix    = neg_q_reg ? -dvd_step : dvd_step;
    r_fix    = neg_r_reg ? -rem_step : rem_step;
  end

  // Control FSM and the iteration counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start && !b_is_zero) begin
            state_reg <= ST_RUN;
            cnt_reg   <= CNT_INIT;
          end
        end
        ST_RUN: begin
          if (cnt_reg == '0) begin
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Operand capture on acceptance, then one shift/subtract step per RUN cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_reg      <= '0;
      dvd_reg      <= '0;
      dvs_reg      <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      ovf_pend_reg <= 1'b0;
    end else if (state_reg == ST_IDLE) begin
      if (bus.start && !b_is_zero) begin
        rem_reg      <= '0;
        dvd_reg      <= a_mag;
        dvs_reg      <= b_mag;
        neg_q_reg    <= bus.signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        neg_r_reg    <= bus.signed_op && bus.a[WIDTH-1];
        ovf_pend_reg <= ovf_case;
      end
    end else begin
      rem_reg <= rem_step;
      dvd_reg <= dvd_step;
    end
  end

  // Result and flag registers. Results hold between operations, flags clear
  // on acceptance, and done pulses for exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient_reg  <= '0;
      remainder_reg <= '0;
      div_zero_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == ST_IDLE) begin
        if (bus.start) begin
          div_zero_reg <= 1'b0;
          overflow_reg <= 1'b0;
          if (b_is_zero) begin
            // Divide-by-zero short-circuits: the dividend is handed back as
            // the remainder and the divider never enters RUN
            quotient_reg  <= '0;
            remainder_reg <= bus.a;
            div_zero_reg  <= 1'b1;
            done_reg      <= 1'b1;
          end
        end
      end else if (cnt_reg == '0) begin
        quotient_reg  <= q_fix;
        remainder_reg <= r_fix;
        overflow_reg  <= ovf_pend_reg;
        done_reg      <= 1'b1;
      end
    end
  end

  assign bus.busy      = (state_reg == ST_RUN);
  assign bus.done      = done_reg;
  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
  assign bus.div_zero  = div_zero_reg;
  assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div. It covers a vector table on an 8-bit instance and
// hand-written handshake, reset-abort and 16-bit sequences. Expected
// results go into a scoreboard queue when a request is accepted. They are
// popped and compared, including the arrival cycle, when done is seen.
module tb_seq_div;
  logic clk;
  logic rst8;
  logic rst16;
  int   cyc;
  int   checks;
  int   failures;

  seq_div_if #(.WIDTH(8))  if8 ();
  seq_div_if #(.WIDTH(16)) if16 ();

  seq_div #(.WIDTH(8))  dut8  (.clk(clk), .reset(rst8),  .bus(if8));
  seq_div #(.WIDTH(16)) dut16 (.clk(clk), .reset(rst16), .bus(if16));

  typedef struct {
    logic       s;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
    int          due;
  } exp_t;

  exp_t sb8[$];
  exp_t sb16[$];
  vec_t vecs[14];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard compare for the 8-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst8 && if8.done) begin
      $display("w8  done cyc=%0d q=%02h r=%02h dz=%0b ov=%0b", cyc, if8.quotient,
               if8.remainder, if8.div_zero, if8.overflow);
      if (sb8.size() == 0) begin
        chk("unexpected_done8", 32'd1, 32'd0);
      end else begin
        e = sb8.pop_front();
        chk("quotient8", {24'h0, if8.quotient}, {16'h0, e.q});
        chk("remainder8", {24'h0, if8.remainder}, {16'h0, e.r});
        chk("div_zero8", {31'h0, if8.div_zero}, {31'h0, e.dz});
        chk("overflow8", {31'h0, if8.overflow}, {31'h0, e.ov});
        chk("done_cycle8", cyc, e.due);
        chk("busy_at_done8", {31'h0, if8.busy}, 32'd0);
      end
    end
  end

  // Scoreboard compare for the 16-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst16 && if16.done) begin
      $display("w16 done cyc=%0d q=%04h r=%04h dz=%0b ov=%0b", cyc, if16.quotient,
               if16.remainder, if16.div_zero, if16.overflow);
      if (sb16.size() == 0) begin
        chk("unexpected_done16", 32'd1, 32'd0);
      end else begin
        e = sb16.pop_front();
        chk("quotient16", {16'h0, if16.quotient}, {16'h0, e.q});
        chk("remainder16", {16'h0, if16.remainder}, {16'h0, e.r});
        chk("div_zero16", {31'h0, if16.div_zero}, {31'h0, e.dz});
        chk("overflow16", {31'h0, if16.overflow}, {31'h0, e.ov});
        chk("done_cycle16", cyc, e.due);
      end
    end
  end

  // Caller is at a negedge. Drive one request and push its expectation
  // once the accepting edge has passed.
  task automatic launch8(input logic s, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] q, input logic [7:0] r,
                         input logic dz, input logic ov);
    exp_t e;
    if8.signed_op = s;
    if8.a         = a;
    if8.b         = b;
    if8.start     = 1'b1;
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    e.q   = {8'h0, q};
    e.r   = {8'h0, r};
    e.dz  = dz;
    e.ov  = ov;
    e.due = cyc + ((b == 8'h0) ? 0 : 8);
    chk("busy_after_accept8", {31'h0, if8.busy}, {31'h0, (b != 8'h0)});
    sb8.push_back(e);
    $display("w8  start cyc=%0d s=%0b a=%02h b=%02h", cyc, s, a, b);
  endtask

  task automatic launch16(input logic s, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] q, input logic [15:0] r);
    exp_t e;
    if16.signed_op = s;
    if16.a         = a;
    if16.b         = b;
    if16.start     = 1'b1;
    @(posedge clk);
    #1;
    if16.start = 1'b0;
    e.q   = q;
    e.r   = r;
    e.dz  = 1'b0;
    e.ov  = 1'b0;
    e.due = cyc + 16;
    chk("busy_after_accept16", {31'h0, if16.busy}, 32'd1);
    sb16.push_back(e);
    $display("w16 start cyc=%0d s=%0b a=%04h b=%04h", cyc, s, a, b);
  endtask

  task automatic drain8();
    for (int i = 0; i < 40 && sb8.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb8.size() != 0) begin
      chk("timeout_done8", 32'd0, 32'd1);
      sb8.delete();
    end
  endtask

  task automatic drain16();
    for (int i = 0; i < 60 && sb16.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb16.size() != 0) begin
      chk("timeout_done16", 32'd0, 32'd1);
      sb16.delete();
    end
  endtask

  task automatic chk_zero8(input string tag);
    chk({tag, "_busy"}, {31'h0, if8.busy}, 32'd0);
    chk({tag, "_done"}, {31'h0, if8.done}, 32'd0);
    chk({tag, "_q"}, {24'h0, if8.quotient}, 32'd0);
    chk({tag, "_r"}, {24'h0, if8.remainder}, 32'd0);
    chk({tag, "_dz"}, {31'h0, if8.div_zero}, 32'd0);
    chk({tag, "_ov"}, {31'h0, if8.overflow}, 32'd0);
  endtask

  initial begin
    bit got_done;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    if8.start  = 1'b0; if8.signed_op  = 1'b0; if8.a  = '0; if8.b  = '0;
    if16.start = 1'b0; if16.signed_op = 1'b0; if16.a = '0; if16.b = '0;

    //         s     a      b      q      r      dz    ov
    vecs[0]  = '{1'b0, 8'd200, 8'd7,  8'd28,  8'd4,  1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h9C,  8'd7,  8'hF2,  8'hFE, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'd100, 8'hF9, 8'hF2,  8'h02, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'd55,  8'd0,  8'd0,   8'd55, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'd9,   8'd3,  8'd3,   8'd0,  1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h80,  8'hFF, 8'h80,  8'h00, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 8'h80,  8'hFF, 8'h00,  8'h80, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'hF9,  8'd2,  8'hFD,  8'hFF, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'd7,   8'hFE, 8'hFD,  8'h01, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h80,  8'd1,  8'h80,  8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'd255, 8'd1,  8'd255, 8'd0,  1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'd0,   8'd5,  8'd0,   8'd0,  1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'h80,  8'd0,  8'd0,   8'h80, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 8'd250, 8'd251, 8'd0,  8'd250, 1'b0, 1'b0};

    // Reset state
    rst8  = 1'b1;
    rst16 = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero8("reset8");
    chk("reset16_busy", {31'h0, if16.busy}, 32'd0);
    chk("reset16_q", {16'h0, if16.quotient}, 32'd0);
    rst8  = 1'b0;
    rst16 = 1'b0;

    // Table-driven vectors on the 8-bit instance
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      launch8(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov);
      drain8();
    end

    // Start pulses during RUN with other operands are ignored
    @(negedge clk);
    launch8(1'b0, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      if8.a = 8'd50; if8.b = 8'd5; if8.start = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
    end
    drain8();
    repeat (12) @(negedge clk);

    // Back-to-back: start in the done cycle is accepted
    @(negedge clk);
    launch8(1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      @(negedge clk);
      got_done = if8.done;
    end
    chk("b2b_first_done8", {31'h0, got_done}, 32'd1);
    launch8(1'b0, 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0);
    drain8();

    // Reset at edge 4 of a RUN aborts; a fresh request completes
    @(negedge clk);
    launch8(1'b0, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst8 = 1'b1;
    #1;
    chk_zero8("midrun_reset8");
    sb8.delete();
    @(negedge clk);
    rst8 = 1'b0;
    repeat (12) @(negedge clk);
    chk_zero8("after_abort8");
    launch8(1'b0, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0);
    drain8();

    // 16-bit instance: a signed case, then the reset-abort repeat
    @(negedge clk);
    launch16(1'b1, 16'h8AD0, 16'd123, 16'hFF0D, 16'hFF91);
    drain16();
    @(negedge clk);
    launch16(1'b0, 16'd65535, 16'd255, 16'd257, 16'd0);
    repeat (4) @(posedge clk);
    #2;
    rst16 = 1'b1;
    #1;
    chk("midrun_reset16_busy", {31'h0, if16.busy}, 32'd0);
    chk("midrun_reset16_q", {16'h0, if16.quotient}, 32'd0);
    chk("midrun_reset16_r", {16'h0, if16.remainder}, 32'd0);
    sb16.delete();
    @(negedge clk);
    rst16 = 1'b0;
    repeat (20) @(negedge clk);
    launch16(1'b0, 16'd65535, 16'd255, 16'd257, 16'd0);
    drain16();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
